additionneur_sequentiel: RTL

//  Parametrised multi-cycle adder/subtractor: WIDTH-bit operands, CHUNK bits per clock,

---
 rtl/additionneur_sequentiel_pkg.sv | 21 ++
 rtl/additionneur_1bit.sv | 14 +
 rtl/additionneur_nbit.sv | 31 +++
 rtl/additionneur_sequentiel.sv | 130 +++++++++++++
 4 files changed

// File: rtl/additionneur_sequentiel_pkg.sv
// Shared definitions for the sequential adder family.
// FSM state encoding and counter-width helper.
package additionneur_sequentiel_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    // ceil(log2(n)), never less than one bit
    function automatic int cnt_width(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) begin
            w++;
        end
        return w;
    endfunction

endpackage

// File: rtl/additionneur_1bit.sv
// Full-adder cell.
// Bit-level building block of the ripple chain.
module additionneur_1bit (
    input  logic a,
    input  logic b,
    input  logic rin,
    output logic s,
    output logic rout
);

    assign s    = a ^ b ^ rin;
    assign rout = (a & b) | (rin & (a ^ b));

endmodule

// File: rtl/additionneur_nbit.sv
// Combinational W-bit ripple adder built from 1-bit cells.
// Also exports the carry entering the MSB for overflow detection.
module additionneur_nbit #(
    parameter int W = 1
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         rin,
    output logic [W-1:0] s,
    output logic         rout,
    output logic         cmsb
);

    logic [W:0] c;

    assign c[0] = rin;

    for (genvar i = 0; i < W; i++) begin : g_bit
        additionneur_1bit u_bit (
            .a    (a[i]),
            .b    (b[i]),
            .rin  (c[i]),
            .s    (s[i]),
            .rout (c[i+1])
        );
    end

    assign rout = c[W];
    assign cmsb = c[W-1];

endmodule

// File: rtl/additionneur_sequentiel.sv
// Multi-cycle adder/subtractor, CHUNK bits per clock.
// Valid/ready on both sides; result held in DONE until taken.
module additionneur_sequentiel
    import additionneur_sequentiel_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CHUNK = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             rin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             rout,
    output logic             ovf
);

    if (WIDTH < 1 || CHUNK < 1 || CHUNK > WIDTH
        || (WIDTH % CHUNK) != 0) begin : g_bad_cfg
        $fatal(1, "additionneur_sequentiel: invalid WIDTH/CHUNK");
    end

    localparam int N  = WIDTH / CHUNK;
    localparam int CW = cnt_width(N);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic             rout_q, rout_d;
    logic             ovf_q, ovf_d;
    logic             run_q;

    logic [CHUNK-1:0] ca, cb, cs;
    logic             co, cm;

    assign ca = a_q[cnt_q*CHUNK +: CHUNK];
    assign cb = b_q[cnt_q*CHUNK +: CHUNK];

    additionneur_nbit #(
        .W (CHUNK)
    ) u_nbit (
        .a    (ca),
        .b    (cb),
        .rin  (carry_q),
        .s    (cs),
        .rout (co),
        .cmsb (cm)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        s_d     = s_q;
        rout_d  = rout_q;
        ovf_d   = ovf_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid && run_q) begin
                    a_d     = a;
                    b_d     = sub ? ~b : b;
                    carry_d = sub ? ~rin : rin;
                    cnt_d   = '0;
                    state_d = CALC;
                end
            end
            CALC: begin
                s_d[cnt_q*CHUNK +: CHUNK] = cs;
                carry_d = co;
                if (cnt_q == LAST) begin
                    rout_d  = co;
                    ovf_d   = co ^ cm;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            s_q     <= '0;
            rout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            run_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            s_q     <= s_d;
            rout_q  <= rout_d;
            ovf_q   <= ovf_d;
            run_q   <= 1'b1;
        end
    end

    // run_q keeps in_ready low until the first edge out of reset
    assign in_ready  = run_q && (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign s         = s_q;
    assign rout      = rout_q;
    assign ovf       = ovf_q;

endmodule
